// File: rtl/divider_array_pkg.sv
// rtl/divider_array_pkg.sv - shared widths, FSM encoding and saturation constant for the array divider
package divider_array_pkg;
  localparam int N_W = 16;
  localparam int D_W = 8;
  localparam int Q_W = 8;
  localparam logic [Q_W-1:0] Q_SAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/divider_array_seq_if.sv
// rtl/divider_array_seq_if.sv - operand request / result handshake bundle for divider_array_seq
interface divider_array_seq_if;
  import divider_array_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] in_n;
  logic [D_W-1:0] in_d;
  logic           out_valid;
  logic           out_ready;
  logic [Q_W-1:0] out_q;
  logic [D_W-1:0] out_r;
  logic           out_dbz;
  logic           out_ovf;

  modport slave (
    input  in_valid, in_n, in_d, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dbz, out_ovf
  );

  modport master (
    output in_valid, in_n, in_d, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_dbz, out_ovf
  );
endinterface

// File: rtl/divider_array_seq_array.sv
// rtl/divider_array_seq_array.sv - combinational restoring divider array, one trial-subtract row per quotient bit
// Valid only when the dividend high byte is below the divisor; the caller screens the other cases.
module divider_array_row_2_approx_div_113_113
  import divider_array_pkg::*;
(
  input  logic [N_W-1:0] i_n,
  input  logic [D_W-1:0] i_d,
  output logic [Q_W-1:0] o_q,
  output logic [D_W-1:0] o_r
);

  logic [D_W-1:0] w_rem;
  logic [D_W:0]   w_trial;
  logic [D_W+1:0] w_diff;

  always_comb begin
    w_rem   = i_n[N_W-1:Q_W];
    w_trial = '0;
    w_diff  = '0;
    o_q     = '0;
    for (int i = Q_W - 1; i >= 0; i--) begin
      w_trial = {w_rem, i_n[i]};
      w_diff  = {1'b0, w_trial} - {2'b00, i_d};
      // A clear borrow bit means the divisor fits into this row's partial remainder.
      if (!w_diff[D_W+1]) begin
        o_q[i] = 1'b1;
        w_rem  = w_diff[D_W-1:0];
      end else begin
        w_rem  = w_trial[D_W-1:0];
      end
    end
    o_r = w_rem;
  end

endmodule

// File: rtl/divider_array_seq.sv
// rtl/divider_array_seq.sv - sequential wrapper: registers operands, waits for the array to settle, handshakes result
module divider_array_seq
  import divider_array_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  divider_array_seq_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t         r_state;
  state_t         w_next_state;
  logic [N_W-1:0] r_n;
  logic [D_W-1:0] r_d;
  logic [3:0]     r_cnt;
  logic [Q_W-1:0] r_q;
  logic [D_W-1:0] r_r;
  logic           r_dbz;
  logic           r_ovf;

  logic           w_accept;
  logic           w_dbz;
  logic           w_ovf;
  logic           w_settled;
  logic [Q_W-1:0] w_arr_q;
  logic [D_W-1:0] w_arr_r;

  divider_array_row_2_approx_div_113_113 u_array (
    .i_n (r_n),
    .i_d (r_d),
    .o_q (w_arr_q),
    .o_r (w_arr_r)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = bus.in_valid && (r_state == IDLE);
    w_dbz        = (bus.in_d == '0);
    // Divide-by-zero wins, so overflow is only raised for a non-zero divisor.
    w_ovf        = !w_dbz && (bus.in_n[N_W-1:Q_W] >= bus.in_d);
    w_settled    = (r_cnt == 4'd0);
    case (r_state)
      IDLE:    if (w_accept) w_next_state = (w_dbz || w_ovf) ? DONE : EXEC;
      EXEC:    if (w_settled) w_next_state = DONE;
      DONE:    if (bus.out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_n <= bus.in_n;
      r_d <= bus.in_d;
      if (w_dbz || w_ovf) begin
        r_q   <= Q_SAT;
        r_r   <= bus.in_n[D_W-1:0];
        r_dbz <= w_dbz;
        r_ovf <= w_ovf;
      end else begin
        r_cnt <= CNT_LOAD;
      end
    end else if (r_state == EXEC) begin
      if (w_settled) begin
        r_q   <= w_arr_q;
        r_r   <= w_arr_r;
        r_dbz <= 1'b0;
        r_ovf <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_q     = r_q;
  assign bus.out_r     = r_r;
  assign bus.out_dbz   = r_dbz;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_divider_array_seq.sv
// tb/tb_divider_array_seq.sv - scoreboard bench for divider_array_seq at SETTLE_CYCLES 2, 1 and 15
module tb_divider_array_seq;
  import divider_array_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  divider_array_seq_if bus0();
  divider_array_seq_if bus1();
  divider_array_seq_if bus2();

  divider_array_seq #(.SETTLE_CYCLES(2))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  divider_array_seq #(.SETTLE_CYCLES(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  divider_array_seq #(.SETTLE_CYCLES(15)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [2:0] tb_in_valid;
  logic [2:0] tb_out_ready;
  logic [15:0] tb_in_n [3];
  logic [7:0]  tb_in_d [3];
  logic [2:0] mon_in_ready, mon_valid, mon_dbz, mon_ovf;
  logic [7:0] mon_q [3];
  logic [7:0] mon_r [3];

  assign bus0.in_valid = tb_in_valid[0];
  assign bus0.in_n = tb_in_n[0];
  assign bus0.in_d = tb_in_d[0];
  assign bus0.out_ready = tb_out_ready[0];
  assign bus1.in_valid = tb_in_valid[1];
  assign bus1.in_n = tb_in_n[1];
  assign bus1.in_d = tb_in_d[1];
  assign bus1.out_ready = tb_out_ready[1];
  assign bus2.in_valid = tb_in_valid[2];
  assign bus2.in_n = tb_in_n[2];
  assign bus2.in_d = tb_in_d[2];
  assign bus2.out_ready = tb_out_ready[2];

  assign mon_in_ready = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
  assign mon_valid    = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign mon_dbz      = {bus2.out_dbz, bus1.out_dbz, bus0.out_dbz};
  assign mon_ovf      = {bus2.out_ovf, bus1.out_ovf, bus0.out_ovf};
  assign mon_q[0] = bus0.out_q;
  assign mon_q[1] = bus1.out_q;
  assign mon_q[2] = bus2.out_q;
  assign mon_r[0] = bus0.out_r;
  assign mon_r[1] = bus1.out_r;
  assign mon_r[2] = bus2.out_r;

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         vcyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every valid cycle against the scoreboard head, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (mon_valid[i] === 1'b1) begin
          if (sb.size() == 0 || sb[0].dut != i) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: got out_valid=1 expected no pending result", i);
          end else begin
            check($sformatf("result_dut%0d", i),
                  {14'd0, mon_q[i], mon_r[i], mon_dbz[i], mon_ovf[i]},
                  {14'd0, sb[0].q, sb[0].r, sb[0].dbz, sb[0].ovf});
            if (!seen[i]) begin
              seen[i] = 1'b1;
              check($sformatf("latency_dut%0d", i), cyc, sb[0].vcyc);
            end
            if (tb_out_ready[i]) begin
              void'(sb.pop_front());
              seen[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic issue(input int k, input logic [15:0] n, input logic [7:0] d,
                       input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                       input logic eovf, input bit push, input bit hold);
    int t;
    exp_t e;
    @(negedge clk);
    tb_in_n[k] = n;
    tb_in_d[k] = d;
    tb_in_valid[k] = 1'b1;
    t = 0;
    while (!mon_in_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!mon_in_ready[k]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 expected 1 within 50 cycles", k);
      tb_in_valid[k] = 1'b0;
      return;
    end
    if (push) begin
      e.dut = k; e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
      e.vcyc = cyc + ((edbz || eovf) ? 1 : settle_of(k) + 1);
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) tb_in_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    tb_in_valid = '0;
    tb_out_ready = '1;
    for (int i = 0; i < 3; i++) begin
      tb_in_n[i] = '0;
      tb_in_d[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_in_ready_dut%0d", i), mon_in_ready[i], 1);
      check($sformatf("reset_outputs_dut%0d", i),
            {mon_valid[i], mon_q[i], mon_r[i], mon_dbz[i], mon_ovf[i]}, 0);
    end

    issue(0, 16'h0064, 8'h07, 8'h0E, 8'h02, 0, 0, 1, 0);
    issue(0, 16'h1234, 8'h00, 8'hFF, 8'h34, 1, 0, 1, 0);
    issue(0, 16'h1234, 8'h10, 8'hFF, 8'h34, 0, 1, 1, 0);
    issue(0, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 1, 0);
    issue(0, 16'h00FF, 8'h00, 8'hFF, 8'hFF, 1, 0, 1, 0);
    issue(0, 16'h0000, 8'h05, 8'h00, 8'h00, 0, 0, 1, 0);
    issue(0, 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 0, 0, 1, 0);
    issue(0, 16'h0705, 8'h07, 8'hFF, 8'h05, 0, 1, 1, 0);
    issue(0, 16'h0100, 8'h02, 8'h80, 8'h00, 0, 0, 1, 0);
    drain();

    // Back-pressure with in_valid held high throughout the stall.
    tb_out_ready[0] = 1'b0;
    issue(0, 16'h0A00, 8'h0B, 8'hE8, 8'h08, 0, 0, 1, 1);
    t = 0;
    while (!mon_valid[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", mon_in_ready[0], 0);
      check("stall_valid", mon_valid[0], 1);
    end
    @(negedge clk);
    tb_out_ready[0] = 1'b1;
    tb_in_valid[0] = 1'b0;
    @(negedge clk);
    check("release_in_ready", mon_in_ready[0], 1);
    check("release_valid", mon_valid[0], 0);
    drain();

    // Reset while the operation is in EXEC: result must be discarded.
    issue(0, 16'h0064, 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);
    check("exec_before_reset", {mon_in_ready[0], mon_valid[0]}, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_exec_in_ready", mon_in_ready[0], 1);
    check("rst_exec_outputs", {mon_valid[0], mon_q[0], mon_r[0], mon_dbz[0], mon_ovf[0]}, 0);
    repeat (5) @(negedge clk);
    check("rst_exec_no_valid", mon_valid[0], 0);

    issue(1, 16'h00FF, 8'h03, 8'h55, 8'h00, 0, 0, 1, 0);
    drain();
    issue(2, 16'h00FF, 8'h03, 8'h55, 8'h00, 0, 0, 1, 0);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
